button_conditioner: RTL and testbench

Parametrised, multi-channel input conditioner for the push-buttons feeding the game core and display controls. For each raw asynchronous input it provides metastability synchronisation, a debounced level, and one-cycle press and release strobes. It also generates an optional per-channel auto-repeat strobe for held buttons. It is the successor to the fixed five-button debouncer: channel count, stability window and sync depth are parameters, and edge and repeat events are new.

---
 rtl/button_pkg.sv | 25 ++
 rtl/button_channel.sv | 168 ++++++++++++++++
 rtl/button_conditioner.sv | 46 ++++
 tb/tb_button_conditioner.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// button_pkg: shared types and helpers for the button conditioner.
//   btn_state_t : per-channel debounce / auto-repeat FSM state
//   cnt_width   : counter width able to hold 0 .. max_count-1 (never 0 bits)
//   max_int     : larger of two integers, for sizing a shared counter
package button_pkg;

  typedef enum logic [2:0] {
    ST_RELEASED     = 3'd0,
    ST_PRESS_PEND   = 3'd1,
    ST_HELD_DELAY   = 3'd2,
    ST_HELD_REPEAT  = 3'd3,
    ST_RELEASE_PEND = 3'd4
  } btn_state_t;

  function automatic int cnt_width(input int max_count);
    int w;
    w = $clog2(max_count);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_channel.sv
// button_channel: one conditioned button.
//   clock, reset   : sole clock, synchronous active-high reset
//   raw            : asynchronous button input
//   repeat_en      : auto-repeat enable (synchronous)
//   level          : debounced level
//   press          : one-cycle strobe on level 0->1
//   release_stb    : one-cycle strobe on level 1->0
//   repeat_stb     : one-cycle auto-repeat strobe while held
// The strobe ports carry a _stb suffix because "release" and "repeat" are
// reserved words in SystemVerilog.
module button_channel
  import button_pkg::*;
#(
  parameter int STABLE_CYCLES = 1_000_000,
  parameter int SYNC_STAGES   = 2,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  input  logic repeat_en,
  output logic level,
  output logic press,
  output logic release_stb,
  output logic repeat_stb
);

  localparam int SC_W = cnt_width(STABLE_CYCLES);
  localparam int RC_W = cnt_width(max_int(REPEAT_DELAY, REPEAT_PERIOD));

  localparam logic [SC_W-1:0] SC_ZERO = {SC_W{1'b0}};
  localparam logic [SC_W-1:0] SC_ONE  = SC_W'(1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(STABLE_CYCLES - 1);
  localparam logic [RC_W-1:0] RC_ZERO = {RC_W{1'b0}};
  localparam logic [RC_W-1:0] RC_ONE  = RC_W'(1);
  localparam logic [RC_W-1:0] RC_DELAY_LAST  = RC_W'(REPEAT_DELAY - 1);
  localparam logic [RC_W-1:0] RC_PERIOD_LAST = RC_W'(REPEAT_PERIOD - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  btn_state_t             state_q, state_d;
  logic [SC_W-1:0]        sc_q, sc_d;
  logic [RC_W-1:0]        rc_q, rc_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;
  logic                   repeat_q, repeat_d;
  logic                   s;

  // Synchroniser chain: bit 0 samples raw, the top bit is the usable value s.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], raw};
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Next-state logic for debounce window, level, strobes and repeat timer.
  always_comb begin
    state_d   = state_q;
    sc_d      = sc_q;
    rc_d      = rc_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;
    case (state_q)
      ST_RELEASED: begin
        if (s) begin
          state_d = ST_PRESS_PEND;
          sc_d    = SC_ONE;
        end else begin
          sc_d = SC_ZERO;
        end
      end
      ST_PRESS_PEND: begin
        if (!s) begin
          // a single cycle of agreement discards the whole window
          state_d = ST_RELEASED;
          sc_d    = SC_ZERO;
        end else if (sc_q == SC_LAST) begin
          state_d = ST_HELD_DELAY;
          sc_d    = SC_ZERO;
          rc_d    = RC_ZERO;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          sc_d = sc_q + SC_ONE;
        end
      end
      ST_HELD_DELAY, ST_HELD_REPEAT: begin
        if (!s) begin
          // rc is left untouched; every exit from RELEASE_PEND reloads it
          state_d = ST_RELEASE_PEND;
          sc_d    = SC_ONE;
        end else if (!repeat_en) begin
          state_d = ST_HELD_DELAY;
          rc_d    = RC_ZERO;
        end else if (state_q == ST_HELD_DELAY) begin
          if (rc_q == RC_DELAY_LAST) begin
            state_d  = ST_HELD_REPEAT;
            rc_d     = RC_ZERO;
            repeat_d = 1'b1;
          end else begin
            rc_d = rc_q + RC_ONE;
          end
        end else begin
          if (rc_q == RC_PERIOD_LAST) begin
            rc_d     = RC_ZERO;
            repeat_d = 1'b1;
          end else begin
            rc_d = rc_q + RC_ONE;
          end
        end
      end
      ST_RELEASE_PEND: begin
        if (s) begin
          // glitch while held: silently resume holding, repeat delay restarts
          state_d = ST_HELD_DELAY;
          sc_d    = SC_ZERO;
          rc_d    = RC_ZERO;
        end else if (sc_q == SC_LAST) begin
          state_d   = ST_RELEASED;
          sc_d      = SC_ZERO;
          rc_d      = RC_ZERO;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          sc_d = sc_q + SC_ONE;
        end
      end
      default: begin
        state_d = ST_RELEASED;
        sc_d    = SC_ZERO;
        rc_d    = RC_ZERO;
        level_d = 1'b0;
      end
    endcase
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q    <= {SYNC_STAGES{1'b0}};
      state_q   <= ST_RELEASED;
      sc_q      <= SC_ZERO;
      rc_q      <= RC_ZERO;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      sc_q      <= sc_d;
      rc_q      <= rc_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
    end
  end

  assign level       = level_q;
  assign press       = press_q;
  assign release_stb = release_q;
  assign repeat_stb  = repeat_q;

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: CHANNELS independent push-button conditioners.
//   clock, reset   : sole clock, synchronous active-high reset
//   raw            : asynchronous button inputs, active-high
//   repeat_en      : per-channel auto-repeat enable
//   level          : debounced levels
//   press          : one-cycle strobes on level 0->1
//   release_stb    : one-cycle strobes on level 1->0
//   repeat_stb     : one-cycle auto-repeat strobes
module button_conditioner
  import button_pkg::*;
#(
  parameter int CHANNELS      = 5,
  parameter int STABLE_CYCLES = 1_000_000,
  parameter int SYNC_STAGES   = 2,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] raw,
  input  logic [CHANNELS-1:0] repeat_en,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] release_stb,
  output logic [CHANNELS-1:0] repeat_stb
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    button_channel #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .SYNC_STAGES  (SYNC_STAGES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_channel (
      .clock      (clock),
      .reset      (reset),
      .raw        (raw[i]),
      .repeat_en  (repeat_en[i]),
      .level      (level[i]),
      .press      (press[i]),
      .release_stb(release_stb[i]),
      .repeat_stb (repeat_stb[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random stimulus,
// every cycle compared with a behavioural model based on run lengths of
// disagreement and elapsed hold time.
module tb_button_conditioner;

  localparam int CH  = 5;
  localparam int STB = 4;
  localparam int SYN = 2;
  localparam int DLY = 10;
  localparam int PER = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [CH-1:0] raw = '0;
  logic [CH-1:0] repeat_en = '0;
  logic [CH-1:0] level, press, release_stb, repeat_stb;

  button_conditioner #(
    .CHANNELS(CH), .STABLE_CYCLES(STB), .SYNC_STAGES(SYN),
    .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)
  ) dut (
    .clock(clock), .reset(reset), .raw(raw), .repeat_en(repeat_en),
    .level(level), .press(press), .release_stb(release_stb), .repeat_stb(repeat_stb)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // reference model state
  bit m_pipe [CH][SYN];
  bit m_level [CH];
  int m_dis [CH];
  int m_since [CH];
  logic [CH-1:0] exp_level, exp_press, exp_rel, exp_rpt;

  // event statistics
  int press_cnt [CH];
  int rel_cnt [CH];
  int last_press [CH];
  int last_rel [CH];
  int rpt_log [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic void model_step(input logic [CH-1:0] r, input logic [CH-1:0] e, input logic rs);
    exp_press = '0; exp_rel = '0; exp_rpt = '0;
    for (int c = 0; c < CH; c++) begin
      if (rs) begin
        for (int k = 0; k < SYN; k++) m_pipe[c][k] = 1'b0;
        m_level[c] = 1'b0; m_dis[c] = 0; m_since[c] = 0;
      end else begin
        bit sv;
        bit was_pending;
        sv = m_pipe[c][SYN-1];
        if (sv != m_level[c]) begin
          m_dis[c]++;
          if (m_dis[c] == STB) begin
            m_level[c] = sv;
            m_dis[c] = 0;
            m_since[c] = 0;
            if (sv) exp_press[c] = 1'b1;
            else exp_rel[c] = 1'b1;
          end
        end else begin
          was_pending = (m_dis[c] > 0);
          m_dis[c] = 0;
          if (m_level[c]) begin
            if (was_pending || !e[c]) m_since[c] = 0;
            else begin
              m_since[c]++;
              if (m_since[c] == DLY || (m_since[c] > DLY && (m_since[c] - DLY) % PER == 0))
                exp_rpt[c] = 1'b1;
            end
          end
        end
        for (int k = SYN - 1; k > 0; k--) m_pipe[c][k] = m_pipe[c][k-1];
        m_pipe[c][0] = r[c];
      end
      exp_level[c] = m_level[c];
    end
  endfunction

  task automatic step(input logic [CH-1:0] r, input logic [CH-1:0] e, input logic rs);
    raw = r; repeat_en = e; reset = rs;
    @(posedge clock);
    model_step(r, e, rs);
    #1;
    chk("level", level, exp_level);
    chk("press", press, exp_press);
    chk("release", release_stb, exp_rel);
    chk("repeat", repeat_stb, exp_rpt);
    chk("exclusive", (press & release_stb) | (press & repeat_stb) | (release_stb & repeat_stb), 0);
    for (int c = 0; c < CH; c++) begin
      if (press[c]) begin press_cnt[c]++; last_press[c] = cyc; end
      if (release_stb[c]) begin rel_cnt[c]++; last_rel[c] = cyc; end
      if (repeat_stb[c]) rpt_log.push_back(cyc * 8 + c);
    end
    cyc++;
  endtask

  task automatic run(input logic [CH-1:0] r, input logic [CH-1:0] e, input logic rs, input int n);
    for (int i = 0; i < n; i++) step(r, e, rs);
  endtask

  function automatic void clear_stats();
    for (int c = 0; c < CH; c++) begin
      press_cnt[c] = 0; rel_cnt[c] = 0; last_press[c] = -1; last_rel[c] = -1;
    end
    rpt_log.delete();
  endfunction

  // cycle of the n-th (from 0) repeat strobe on channel c, -1 if none
  function automatic int nth_rpt(input int c, input int n);
    int k = 0;
    foreach (rpt_log[i]) begin
      if (rpt_log[i] % 8 == c) begin
        if (k == n) return rpt_log[i] / 8;
        k++;
      end
    end
    return -1;
  endfunction

  function automatic int count_rpt(input int c);
    int k = 0;
    foreach (rpt_log[i]) if (rpt_log[i] % 8 == c) k++;
    return k;
  endfunction

  initial begin
    int base, p, g, rr, sum;
    logic [CH-1:0] e, r_raw, r_en;

    for (int c = 0; c < CH; c++) begin
      for (int k = 0; k < SYN; k++) m_pipe[c][k] = 1'b0;
      m_level[c] = 1'b0; m_dis[c] = 0; m_since[c] = 0;
    end
    clear_stats();

    // reset state
    run(5'b00000, 5'b00000, 1'b1, 3);
    chk("reset_level", level, 0);
    chk("reset_strobes", press | release_stb | repeat_stb, 0);

    // clean press and release on ch0
    clear_stats(); base = cyc;
    run(5'b00001, 5'b00000, 1'b0, 12);
    chk("ch0_press_lat", last_press[0] - base, 5);
    chk("ch0_press_once", press_cnt[0], 1);
    chk("others_quiet", press_cnt[1] + press_cnt[2] + press_cnt[3] + press_cnt[4], 0);
    base = cyc;
    run(5'b00000, 5'b00000, 1'b0, 12);
    chk("ch0_rel_lat", last_rel[0] - base, 5);
    chk("ch0_rel_once", rel_cnt[0], 1);

    // bouncing ch1: 1,1,0,1,1,1...
    clear_stats(); base = cyc;
    step(5'b00010, 5'b00000, 1'b0);
    step(5'b00010, 5'b00000, 1'b0);
    step(5'b00000, 5'b00000, 1'b0);
    run(5'b00010, 5'b00000, 1'b0, 12);
    chk("ch1_bounce_lat", last_press[1] - (base + 3), 5);
    chk("ch1_press_once", press_cnt[1], 1);
    run(5'b00000, 5'b00000, 1'b0, 10);

    // ch2 auto-repeat then release
    clear_stats(); base = cyc;
    run(5'b00100, 5'b00100, 1'b0, 22);
    p = last_press[2];
    base = cyc;
    run(5'b00000, 5'b00100, 1'b0, 20);
    chk("ch2_rpt0", nth_rpt(2, 0), p + 10);
    chk("ch2_rpt1", nth_rpt(2, 1), p + 13);
    chk("ch2_rpt2", nth_rpt(2, 2), p + 16);
    chk("ch2_rpt_count", count_rpt(2), 3);
    chk("ch2_rel_once", rel_cnt[2], 1);
    chk("ch2_rel_lat", last_rel[2] - base, 5);

    // ch3 repeat enable dropped for one cycle
    clear_stats(); base = cyc;
    for (int n = 0; n < 32; n++) begin
      e = 5'b01000;
      if (press_cnt[3] > 0 && cyc == last_press[3] + 8) e = 5'b00000;
      step(5'b01000, e, 1'b0);
    end
    p = last_press[3];
    chk("ch3_press_lat", p - base, 5);
    chk("ch3_first_rpt", nth_rpt(3, 0), p + 18);
    chk("ch3_second_rpt", nth_rpt(3, 1), p + 21);
    run(5'b00000, 5'b01000, 1'b0, 10);

    // ch4 two-cycle release glitch while held
    clear_stats(); base = cyc; g = -100;
    for (int n = 0; n < 30; n++) begin
      if (press_cnt[4] > 0 && g < 0) g = last_press[4] + 4;
      step((cyc == g || cyc == g + 1) ? 5'b00000 : 5'b10000, 5'b10000, 1'b0);
    end
    chk("ch4_no_release", rel_cnt[4], 0);
    chk("ch4_press_once", press_cnt[4], 1);
    chk("ch4_first_rpt", nth_rpt(4, 0), g + 14);
    run(5'b00000, 5'b10000, 1'b0, 10);

    // all channels together, reset pulsed mid-hold
    clear_stats(); base = cyc;
    run(5'b11111, 5'b00000, 1'b0, 10);
    for (int c = 0; c < CH; c++) chk("all_press_sync", last_press[c], base + 5);
    run(5'b11111, 5'b00000, 1'b1, 2);
    rr = cyc - 1;
    chk("mid_reset_level", level, 0);
    run(5'b11111, 5'b00000, 1'b0, 10);
    sum = 0;
    for (int c = 0; c < CH; c++) sum += rel_cnt[c];
    chk("mid_reset_no_rel", sum, 0);
    for (int c = 0; c < CH; c++) begin
      chk("repress_lat", last_press[c], rr + 6);
      chk("repress_count", press_cnt[c], 2);
    end
    run(5'b00000, 5'b00000, 1'b0, 10);

    // randomized stimulus against the model
    r_raw = '0; r_en = '0;
    for (int n = 0; n < 900; n++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 5 + 8 * c) == 0) r_raw[c] = ~r_raw[c];
        if ($urandom_range(0, 39) == 0) r_en[c] = ~r_en[c];
      end
      step(r_raw, r_en, ($urandom_range(0, 299) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
